perm_lane_feeder: RTL

- Upstream feeder for the SHA-3 permutation engine.
- Collects a stream of 64-bit Keccak lanes (lane index i = x + 5*y) into a 1600-bit state buffer, zero-padding when a block ends early.
- Then replays the buffer as eight 200-bit chunks with chunk index and push strobe, matching the engine's dix/din/pushin input.
- Blocks the lane stream while replaying.

---
 rtl/perm_pkg.sv | 29 ++
 rtl/perm_lane_feeder.sv | 93 +++++++++
 2 files changed

// File: rtl/perm_pkg.sv
// Shared constants and types for the SHA-3 permutation datapath: lane/chunk
// geometry, the feeder FSM encoding and the 1600-bit state type.
package perm_pkg;

  localparam int LANE_W  = 64;
  localparam int NLANES  = 25;
  localparam int CHUNK_W = 200;
  localparam int NCHUNKS = 8;
  localparam int STATE_W = 1600;

  localparam int LCNT_W = 5;
  localparam int CCNT_W = 3;

  localparam logic [LCNT_W-1:0] LAST_LANE = LCNT_W'(NLANES - 1);

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } feed_state_e;

  typedef logic [STATE_W-1:0] state_t;

  // Chunk k is the plain bit slice [200k+199:200k]; lanes may straddle chunks.
  function automatic logic [CHUNK_W-1:0] chunk_sel(input state_t s,
                                                   input logic [CCNT_W-1:0] k);
    return s[CHUNK_W*k +: CHUNK_W];
  endfunction

endpackage

// File: rtl/perm_lane_feeder.sv
// Packs a 64-bit lane stream into a 1600-bit state and replays it to the
// permutation engine as eight 200-bit chunks (dix/din/pushin).
module perm_lane_feeder
  import perm_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [LANE_W-1:0]  lane,
  input  logic               lane_valid,
  input  logic               lane_last,
  output logic               lane_ready,
  output logic [CCNT_W-1:0]  dix,
  output logic [CHUNK_W-1:0] din,
  output logic               pushin,
  output logic               busy
);

  // Handshake: a lane transfers on a posedge where lane_valid && lane_ready.
  // While lane_ready is low the source must hold lane/lane_last unchanged.
  // pushin has no backpressure: one chunk per cycle for eight cycles.

  feed_state_e        state_q, state_d;
  logic [LCNT_W-1:0]  lane_cnt_q, lane_cnt_d;
  logic [CCNT_W-1:0]  chunk_cnt_q, chunk_cnt_d;
  state_t             buf_q, buf_d;
  logic               pushin_d;
  logic [CCNT_W-1:0]  dix_d;
  logic [CHUNK_W-1:0] din_d;

  assign lane_ready = (state_q == FILL);
  assign busy       = (state_q == EMIT);

  always_comb begin
    state_d     = state_q;
    lane_cnt_d  = lane_cnt_q;
    chunk_cnt_d = chunk_cnt_q;
    buf_d       = buf_q;
    pushin_d    = 1'b0;
    dix_d       = '0;
    din_d       = '0;
    case (state_q)
      FILL: begin
        if (lane_valid) begin
          buf_d[LANE_W*lane_cnt_q +: LANE_W] = lane;
          lane_cnt_d = lane_cnt_q + LCNT_W'(1);
          // Chunk 0 leaves on the completing edge so the burst lines up
          // with lane_ready dropping; it must include the lane just taken.
          if (lane_last || (lane_cnt_q == LAST_LANE)) begin
            state_d     = EMIT;
            pushin_d    = 1'b1;
            din_d       = chunk_sel(buf_d, CCNT_W'(0));
            chunk_cnt_d = CCNT_W'(1);
          end
        end
      end
      EMIT: begin
        if (chunk_cnt_q != '0) begin
          pushin_d    = 1'b1;
          dix_d       = chunk_cnt_q;
          din_d       = chunk_sel(buf_q, chunk_cnt_q);
          chunk_cnt_d = chunk_cnt_q + CCNT_W'(1);
        end else begin
          // Counter wrapped after chunk 7: clear so short blocks zero-pad.
          state_d    = FILL;
          buf_d      = '0;
          lane_cnt_d = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= FILL;
      lane_cnt_q  <= '0;
      chunk_cnt_q <= '0;
      buf_q       <= '0;
      pushin      <= 1'b0;
      dix         <= '0;
      din         <= '0;
    end else begin
      state_q     <= state_d;
      lane_cnt_q  <= lane_cnt_d;
      chunk_cnt_q <= chunk_cnt_d;
      buf_q       <= buf_d;
      pushin      <= pushin_d;
      dix         <= dix_d;
      din         <= din_d;
    end
  end

endmodule
